// File: rtl/key_led_pkg.sv
// Shared types and helpers for the key/LED controller: per-channel FSM states
// and a counter width helper.
package key_led_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } key_state_e;

    // Bits needed for a counter of max_count states, never less than one.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel: 2-flop synchronizer, mismatch-count debouncer and an arm flag
// that is raised only after the key has been seen stably released.
module key_debounce
    import key_led_pkg::*;
#(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_level,
    output logic o_armed
);

    localparam int DB_W  = cnt_width(DB_CYCLES);
    localparam int ARM_W = cnt_width(DB_CYCLES + 2);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(DB_CYCLES + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [DB_W-1:0]  r_cnt;
    logic [ARM_W-1:0] r_arm_cnt;
    logic             r_armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_level   <= 1'b1;
            r_cnt     <= '0;
            r_arm_cnt <= '0;
            r_armed   <= 1'b0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_level) begin
                if (r_cnt == DB_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + DB_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
            // The arm window is longer than the two post-reset cycles in which the
            // synchronizer still shows its reset value, so a key held through
            // reset can never arm before it is really released.
            if (!r_armed) begin
                if (r_sync2 && r_level) begin
                    if (r_arm_cnt == ARM_LAST) begin
                        r_armed <= 1'b1;
                    end else begin
                        r_arm_cnt <= r_arm_cnt + ARM_W'(1);
                    end
                end else begin
                    r_arm_cnt <= '0;
                end
            end
        end
    end

    assign o_level = r_level;
    assign o_armed = r_armed;

endmodule

// File: rtl/key_led_ctrl.sv
// Multi-channel key-to-LED controller: short press toggles the LED, long press
// toggles blink mode; all channels run independently off one blink timebase.
module key_led_ctrl
    import key_led_pkg::*;
#(
    parameter int NUM_KEYS     = 4,
    parameter int DB_CYCLES    = 1000000,
    parameter int LONG_CYCLES  = 50000000,
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] led,
    output logic [NUM_KEYS-1:0] short_pulse,
    output logic [NUM_KEYS-1:0] long_pulse
);

    localparam int HOLD_W  = cnt_width(LONG_CYCLES);
    localparam int BLINK_W = cnt_width(BLINK_CYCLES);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX   = '1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
        end
    end

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : gen_ch
        logic              w_level;
        logic              w_armed;
        key_state_e        r_state;
        key_state_e        w_state_next;
        logic              w_fire_short;
        logic              w_fire_long;
        logic [HOLD_W-1:0] r_hold_cnt;
        logic              r_led_on;
        logic              r_blink_en;
        logic              r_short;
        logic              r_long;
        logic              r_led;

        key_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .i_key   (key[gi]),
            .o_level (w_level),
            .o_armed (w_armed)
        );

        always_comb begin
            w_state_next = r_state;
            w_fire_short = 1'b0;
            w_fire_long  = 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_armed && !w_level) w_state_next = PRESSED;
                end
                PRESSED: begin
                    if (w_level) begin
                        w_state_next = IDLE;
                        w_fire_short = 1'b1;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        w_state_next = LONG;
                        w_fire_long  = 1'b1;
                    end
                end
                LONG: begin
                    if (w_level) w_state_next = IDLE;
                end
                default: w_state_next = IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state    <= IDLE;
                r_hold_cnt <= '0;
                r_led_on   <= 1'b0;
                r_blink_en <= 1'b0;
                r_short    <= 1'b0;
                r_long     <= 1'b0;
                r_led      <= 1'b0;
            end else begin
                r_state <= w_state_next;
                // Cleared whenever not pressed, so every press starts counting at zero.
                if (r_state != PRESSED) begin
                    r_hold_cnt <= '0;
                end else if (r_hold_cnt != HOLD_MAX) begin
                    r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                end
                r_short <= w_fire_short;
                r_long  <= w_fire_long;
                if (w_fire_short) r_led_on   <= ~r_led_on;
                if (w_fire_long)  r_blink_en <= ~r_blink_en;
                r_led <= r_led_on & (r_blink_en ? r_blink_phase : 1'b1);
            end
        end

        assign led[gi]         = r_led;
        assign short_pulse[gi] = r_short;
        assign long_pulse[gi]  = r_long;
    end

endmodule

// File: tb/tb_key_led_ctrl.sv
// Directed bench for key_led_ctrl with short timing parameters: a vector table
// for press/release outcomes plus hand sequences for latency, long press and reset.
module tb_key_led_ctrl;

    localparam int NK = 4;
    localparam int DB = 4;
    localparam int LG = 20;
    localparam int BL = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key = '1;
    logic [NK-1:0] led;
    logic [NK-1:0] short_pulse;
    logic [NK-1:0] long_pulse;

    int checks = 0;
    int errors = 0;

    int      short_cnt [NK];
    int      long_cnt  [NK];
    int      short_events;
    bit [NK-1:0] last_short;

    typedef struct {
        logic [NK-1:0] mask;
        int            hold;
        logic [NK-1:0] exp_short;
        logic [NK-1:0] exp_led;
    } vec_t;

    vec_t vecs [8];

    key_led_ctrl #(
        .NUM_KEYS     (NK),
        .DB_CYCLES    (DB),
        .LONG_CYCLES  (LG),
        .BLINK_CYCLES (BL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .led         (led),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < NK; i++) begin
            if (short_pulse[i] === 1'b1) short_cnt[i] <= short_cnt[i] + 1;
            if (long_pulse[i] === 1'b1)  long_cnt[i]  <= long_cnt[i] + 1;
        end
        if (short_pulse !== '0 && !$isunknown(short_pulse)) begin
            short_events <= short_events + 1;
            last_short   <= short_pulse;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [NK-1:0] mask, input int hold);
        key = ~mask;
        cycles(hold);
        key = '1;
    endtask

    function automatic int long_total();
        int s;
        s = 0;
        for (int i = 0; i < NK; i++) s += long_cnt[i];
        return s;
    endfunction

    initial begin
        int ev0, lt0, sc0, first_k, n, nl, ns, nt, last_t;
        int g1, h1, g2, h2, pos;
        logic prev, led_at7, led_at8;
        int s0 [NK];
        bit [NK-1:0] pat [48];

        vecs[0] = '{4'b0001,  3, 4'b0000, 4'b0000};
        vecs[1] = '{4'b0001, 10, 4'b0001, 4'b0001};
        vecs[2] = '{4'b0001, 10, 4'b0001, 4'b0000};
        vecs[3] = '{4'b1001, 10, 4'b1001, 4'b1001};
        vecs[4] = '{4'b0110,  6, 4'b0110, 4'b1111};
        vecs[5] = '{4'b1111,  2, 4'b0000, 4'b1111};
        vecs[6] = '{4'b0100,  4, 4'b0100, 4'b1011};
        vecs[7] = '{4'b1010, 12, 4'b1010, 4'b0001};

        cycles(3);
        rst = 1'b0;
        check("reset led", int'(led), 0);
        check("reset short_pulse", int'(short_pulse), 0);
        check("reset long_pulse", int'(long_pulse), 0);
        cycles(20);

        for (int v = 0; v < 8; v++) begin
            ev0 = short_events;
            lt0 = long_total();
            press(vecs[v].mask, vecs[v].hold);
            cycles(30);
            check($sformatf("vec%0d short events", v), short_events - ev0,
                  (vecs[v].exp_short != '0) ? 1 : 0);
            if (vecs[v].exp_short != '0)
                check($sformatf("vec%0d short vector", v), int'(last_short), int'(vecs[v].exp_short));
            check($sformatf("vec%0d led", v), int'(led), int'(vecs[v].exp_led));
            check($sformatf("vec%0d long count", v), long_total() - lt0, 0);
        end

        // Exact release-to-strobe latency and registered LED update on channel 0.
        key = 4'b1110;
        cycles(10);
        key = '1;
        first_k = 0;
        n = 0;
        led_at7 = 1'b0;
        led_at8 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (short_pulse[0]) begin
                n++;
                if (first_k == 0) first_k = k;
            end
            if (k == 7) led_at7 = led[0];
            if (k == 8) led_at8 = led[0];
        end
        check("ch0 short latency", first_k, 7);
        check("ch0 short width", n, 1);
        check("ch0 led before update", int'(led_at7), 1);
        check("ch0 led after update", int'(led_at8), 0);
        cycles(20);

        press(4'b0010, 10);
        cycles(30);
        check("ch1 led on", int'(led), 4'b0010);

        // Long hold on channel 1: one long strobe, blinking at half-period BL.
        key = 4'b1101;
        first_k = 0;
        nl = 0;
        ns = 0;
        nt = 0;
        last_t = 0;
        prev = led[1];
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (long_pulse[1]) begin
                nl++;
                if (first_k == 0) first_k = k;
            end
            if (short_pulse[1]) ns++;
            if (k > 28 && led[1] != prev) begin
                if (last_t != 0) check("ch1 blink spacing", k - last_t, BL);
                last_t = k;
                nt++;
            end
            prev = led[1];
            if (k == 40) key = '1;
        end
        check("ch1 long latency", first_k, 27);
        check("ch1 long count", nl, 1);
        check("ch1 short after long", ns, 0);
        check("ch1 blink toggles seen", (nt >= 3) ? 1 : 0, 1);

        // LED off while blink mode stays set; turning on again resumes blinking.
        press(4'b0010, 10);
        cycles(12);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (led[1]) n++;
        end
        check("ch1 dark in blink mode", n, 0);
        press(4'b0010, 10);
        nt = 0;
        prev = led[1];
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k > 10 && led[1] != prev) nt++;
            prev = led[1];
        end
        check("ch1 blink mode retained", (nt >= 2) ? 1 : 0, 1);

        // Reset in the middle of a press on channel 2.
        key = 4'b1011;
        cycles(15);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("midpress reset led", int'(led), 0);
        check("midpress reset short_pulse", int'(short_pulse), 0);
        check("midpress reset long_pulse", int'(long_pulse), 0);
        sc0 = short_cnt[2];
        lt0 = long_total();
        cycles(30);
        key = '1;
        cycles(30);
        check("ch2 held through reset short", short_cnt[2] - sc0, 0);
        check("ch2 held through reset long", long_total() - lt0, 0);
        press(4'b0100, 10);
        cycles(30);
        check("ch2 fresh press short", short_cnt[2] - sc0, 1);

        // Bounce of 1-3 cycles around a 12-cycle press on every key.
        for (int t = 0; t < 48; t++) pat[t] = '1;
        for (int i = 0; i < NK; i++) begin
            g1 = $urandom_range(1, 3);
            h1 = $urandom_range(1, 3);
            g2 = $urandom_range(1, 3);
            h2 = $urandom_range(1, 3);
            pos = 2;
            for (int j = 0; j < g1; j++) pat[pos + j][i] = 1'b0;
            pos = pos + g1 + h1;
            for (int j = 0; j < 12; j++) pat[pos + j][i] = 1'b0;
            pos = pos + 12 + g2;
            for (int j = 0; j < h2; j++) pat[pos + j][i] = 1'b0;
        end
        for (int i = 0; i < NK; i++) s0[i] = short_cnt[i];
        lt0 = long_total();
        for (int t = 0; t < 48; t++) begin
            key = pat[t];
            cycles(1);
        end
        key = '1;
        cycles(20);
        for (int i = 0; i < NK; i++)
            check($sformatf("bounce ch%0d short count", i), short_cnt[i] - s0[i], 1);
        check("bounce long count", long_total() - lt0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
